btn_ctrl: RTL and testbench
===========================

Name: btn_ctrl

Overview:
- Parametrised, memory-mapped push-button controller for NUM_BTNS buttons.
- Per channel: 2-flop synchroniser, counter-based debouncer, press-edge detector and sticky pending bit with clear-on-read.
- Adds a maskable interrupt line.
- Sits on the CPU peripheral bus next to the other MMIO components; replaces the fixed two-button, undebounced peripheral.

Parameters:
- ADDR_WIDTH, 8, width of the peripheral word address.
- NUM_BTNS, 2, number of button channels (1..32).
- DEBOUNCE_CYCLES, 16, cycles a synchronised level must hold before it is accepted (>=2).
- ACTIVE_LOW, 1, 1 means a pad level of 0 is "pressed"; 0 means a pad level of 1 is "pressed".

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn  in  NUM_BTNS  raw asynchronous button pads.
- read_enable  in  1  bus read strobe, one cycle per access.
- write_enable  in  1  bus write strobe, one cycle per access.
- address  in  ADDR_WIDTH  word address.
- data_in  in  32  write data.
- data_out  out  32  read data (combinational).
- irq  out  1  level interrupt, high while any enabled pending bit is set.

Behaviour:
- Reset (async assert, sync release):
  - synchronisers and stable levels are cleared to "not pressed"; counters, pending and irq_en are cleared to 0.
  - irq=0; data_out=0.
- Normalisation: pressed = btn XOR ACTIVE_LOW. All internal state is in "pressed=1" polarity.
- Synchroniser: two flops per channel. sync2 reflects pad level 2 edges later.
- Debouncer, per channel:
  - If sync2==stable, counter <= 0.
  - Otherwise counter increments. On the edge where counter==DEBOUNCE_CYCLES-1 and sync2 still differs, stable <= sync2 and counter <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at sync2 never changes stable.
  - Latency from a clean pad change to stable: DEBOUNCE_CYCLES+2 edges.
- Press event: asserted on the edge where stable goes 0->1. Sets pending[i] on that same edge. Releases (1->0) set nothing.
- Register map (word addresses; addresses >=4 read 0, writes ignored):
  - 0 STATUS (RO): bits[NUM_BTNS-1:0]=stable.
  - 1 PENDING (RO, clear-on-read): bits=pending.
  - 2 IRQ_EN (RW): bits=irq_en.
  - 3 PENDING_PEEK (RO): bits=pending, no side effect.
  - Unused upper bits read 0.
- data_out = register selected by address when read_enable=1, else 0. Valid in the same cycle as the strobe.
- Clear-on-read: at the edge ending a read of address 1, pending <= (pending & ~snapshot) | new_events, where snapshot is the value returned.
  - An event arriving in the read cycle is never lost; it stays pending.
- Writes: at the edge with write_enable && address==2, irq_en <= data_in[NUM_BTNS-1:0]. Writes to other addresses are ignored.
  - If read_enable and write_enable are both high, both take effect.
- irq = |(pending & irq_en), combinational from registers. It drops in the cycle after the clearing read unless a new event occurred.
- Reset mid-debounce discards partial counts. Holding a button through reset release yields one press event DEBOUNCE_CYCLES+2 edges after release.
- Counter width: $clog2(DEBOUNCE_CYCLES). The counter never wraps, because it resets at terminal count.

Decomposition:
- Shared include: register address constants (REG_STATUS=0, REG_PENDING=1, REG_IRQ_EN=2, REG_PEEK=3) for reuse by the bus decoder and firmware headers.
- Sub-module btn_debounce:
  - Contains the synchroniser, counter, stable flop and rise pulse for one channel.
  - Parameter DEBOUNCE_CYCLES.
  - Instantiated NUM_BTNS times in a generate loop.
- The top level holds pending, irq_en and the read mux.

Test Plan (DEBOUNCE_CYCLES=4, NUM_BTNS=2, ACTIVE_LOW=1):
- Reset, then read addresses 0..3 -> all 0, irq=0. Assert rst_n low mid-count -> counter and stable are 0 immediately, without waiting for a clock edge.
- Drive btn[0]=0 and hold -> STATUS bit0=1 exactly 6 edges later; PEEK=0x1. Read address 1 -> returns 0x1; the next read of address 1 returns 0x0.
- Pulse btn[1] low for 3 cycles -> STATUS, PENDING and irq unchanged. Pulse for 8 cycles -> PENDING=0x2.
- Write IRQ_EN=0x1, press btn[1] -> irq stays 0. Press btn[0] -> irq=1. Read address 1 -> irq=0 on the next cycle.
- Align btn[1]'s stable rise with a read of address 1 that returns 0x1 -> next PEEK=0x2, and the bit0 clear is honoured.
- Press and release btn[0] twice without reading -> PENDING=0x1 (sticky, not counted). Release alone sets no pending bit.

Source files
------------

// File: rtl/btn_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// btn_ctrl_pkg
//   Shared definitions for the push-button controller: the word addresses of
//   its registers, the decoded register-select enumeration and the address
//   decoder used by the read mux and the write path.
//   The REG_* constants are the values firmware headers mirror, so they stay
//   plain integers rather than enum members.
// -----------------------------------------------------------------------------
package btn_ctrl_pkg;

    // Register word addresses.
    localparam int unsigned REG_STATUS  = 32'd0;
    localparam int unsigned REG_PENDING = 32'd1;
    localparam int unsigned REG_IRQ_EN  = 32'd2;
    localparam int unsigned REG_PEEK    = 32'd3;

    // One-of selection of the addressed register; SEL_NONE covers every
    // address outside the map (reads return zero, writes are dropped).
    typedef enum logic [2:0] {
        SEL_NONE    = 3'd0,
        SEL_STATUS  = 3'd1,
        SEL_PENDING = 3'd2,
        SEL_IRQ_EN  = 3'd3,
        SEL_PEEK    = 3'd4
    } reg_sel_e;

    // Map a zero-extended word address onto a register select.
    function automatic reg_sel_e decode_reg(input logic [31:0] addr);
        reg_sel_e sel;
        case (addr)
            REG_STATUS:  sel = SEL_STATUS;
            REG_PENDING: sel = SEL_PENDING;
            REG_IRQ_EN:  sel = SEL_IRQ_EN;
            REG_PEEK:    sel = SEL_PEEK;
            default:     sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/btn_ctrl_if.sv
// -----------------------------------------------------------------------------
// btn_ctrl_if
//   Peripheral-bus bundle between the CPU bus fabric and btn_ctrl.
//   Signals:
//     read_enable   one-cycle read strobe
//     write_enable  one-cycle write strobe
//     address       word address (ADDR_WIDTH bits, at most 32)
//     data_in       write data
//     data_out      read data, combinational, zero when not reading
//   Modports:
//     master  bus side (drives strobes, address, write data)
//     slave   peripheral side (returns read data)
// -----------------------------------------------------------------------------
interface btn_ctrl_if #(
    parameter int ADDR_WIDTH = 8
) ();

    logic                  read_enable;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] address;
    logic [31:0]           data_in;
    logic [31:0]           data_out;

    modport master (
        output read_enable,
        output write_enable,
        output address,
        output data_in,
        input  data_out
    );

    modport slave (
        input  read_enable,
        input  write_enable,
        input  address,
        input  data_in,
        output data_out
    );

endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   One button channel: two-flop synchroniser, counter debouncer, accepted
//   (stable) level and a press pulse.
//   Ports:
//     clk     system clock
//     rst_n   asynchronous active-low reset
//     level   raw pad level already normalised to pressed=1 (asynchronous)
//     stable  debounced level, pressed=1
//     rise    high during the cycle whose closing edge moves stable 0->1, so
//             the parent can latch the event on the very same edge
//   A synchronised level must differ from stable on DEBOUNCE_CYCLES
//   consecutive edges before it is accepted; any return to the stable level
//   restarts the count. Pad-to-stable latency is DEBOUNCE_CYCLES+2 edges.
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic stable,
    output logic rise
);

    // Counter only has to reach DEBOUNCE_CYCLES-1 and is cleared there,
    // so it never wraps.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;

    logic             stable_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             rise_s;

    // Two-flop synchroniser for the asynchronous pad level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= level;
            sync2_r <= sync1_r;
        end
    end

    // Debounce decision: count disagreeing edges, accept at terminal count.
    always_comb begin
        stable_nxt_s = stable_r;
        cnt_nxt_s    = cnt_r;
        rise_s       = 1'b0;
        if (sync2_r == stable_r) begin
            cnt_nxt_s = '0;
        end else if (cnt_r == CNT_TERM) begin
            stable_nxt_s = sync2_r;
            cnt_nxt_s    = '0;
            // Only an accepted press counts as an event; releases do not.
            rise_s       = sync2_r;
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // Debounce state: accepted level and disagreement counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_r <= 1'b0;
            cnt_r    <= '0;
        end else begin
            stable_r <= stable_nxt_s;
            cnt_r    <= cnt_nxt_s;
        end
    end

    assign stable = stable_r;
    assign rise   = rise_s;

endmodule

// File: rtl/btn_ctrl.sv
// -----------------------------------------------------------------------------
// btn_ctrl
//   Memory-mapped push-button controller for NUM_BTNS debounced channels with
//   sticky press-pending bits, clear-on-read and a maskable level interrupt.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     btn    raw asynchronous button pads (polarity set by ACTIVE_LOW)
//     bus    btn_ctrl_if.slave peripheral bus (strobes, address, data)
//     irq    high while any enabled pending bit is set
//   Register map (word addresses, everything else reads 0 / ignores writes):
//     0 STATUS        RO  debounced levels
//     1 PENDING       RO  pending presses, cleared by the read
//     2 IRQ_EN        RW  interrupt enables
//     3 PENDING_PEEK  RO  pending presses, no side effect
//   ADDR_WIDTH must be 1..32 and match the connected interface.
// -----------------------------------------------------------------------------
module btn_ctrl
    import btn_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH      = 8,
    parameter int NUM_BTNS        = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_BTNS-1:0] btn,
    btn_ctrl_if.slave           bus,
    output logic                irq
);

    logic [NUM_BTNS-1:0]   pressed_s;
    logic [NUM_BTNS-1:0]   stable_s;
    logic [NUM_BTNS-1:0]   rise_s;

    logic [NUM_BTNS-1:0]   pending_r;
    logic [NUM_BTNS-1:0]   irq_en_r;
    logic [NUM_BTNS-1:0]   pending_nxt_s;
    logic [NUM_BTNS-1:0]   clear_mask_s;

    logic [ADDR_WIDTH-1:0] addr_s;
    reg_sel_e              reg_sel_s;
    logic                  pend_read_s;
    logic                  irq_en_wr_s;
    logic [31:0]           rdata_s;
    logic                  unused_wdata_s;

    // Everything downstream works in pressed=1 polarity.
    assign pressed_s = (ACTIVE_LOW != 0) ? ~btn : btn;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst_n  (rst_n),
            .level  (pressed_s[i]),
            .stable (stable_s[i]),
            .rise   (rise_s[i])
        );
    end

    assign addr_s    = bus.address;
    assign reg_sel_s = decode_reg(32'(addr_s));

    // Only the low NUM_BTNS bits of write data carry register content.
    assign unused_wdata_s = ^(bus.data_in >> NUM_BTNS);

    // Bus access qualifiers for the side-effecting register accesses.
    always_comb begin
        pend_read_s = 1'b0;
        irq_en_wr_s = 1'b0;
        if (bus.read_enable && (reg_sel_s == SEL_PENDING)) begin
            pend_read_s = 1'b1;
        end else begin
            pend_read_s = 1'b0;
        end
        if (bus.write_enable && (reg_sel_s == SEL_IRQ_EN)) begin
            irq_en_wr_s = 1'b1;
        end else begin
            irq_en_wr_s = 1'b0;
        end
    end

    // Pending update: the clearing read removes exactly what it returned,
    // while presses landing on the same edge are still recorded.
    always_comb begin
        clear_mask_s = '0;
        if (pend_read_s) begin
            clear_mask_s = pending_r;
        end else begin
            clear_mask_s = '0;
        end
        pending_nxt_s = (pending_r & ~clear_mask_s) | rise_s;
    end

    // Pending and interrupt-enable registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= '0;
            irq_en_r  <= '0;
        end else begin
            pending_r <= pending_nxt_s;
            if (irq_en_wr_s) begin
                irq_en_r <= bus.data_in[NUM_BTNS-1:0];
            end
        end
    end

    // Read mux; the bus expects data in the same cycle as the strobe.
    always_comb begin
        rdata_s = 32'd0;
        if (bus.read_enable) begin
            case (reg_sel_s)
                SEL_STATUS:  rdata_s = 32'(stable_s);
                SEL_PENDING: rdata_s = 32'(pending_r);
                SEL_IRQ_EN:  rdata_s = 32'(irq_en_r);
                SEL_PEEK:    rdata_s = 32'(pending_r);
                default:     rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign bus.data_out = rdata_s;
    assign irq          = |(pending_r & irq_en_r);

endmodule

// File: tb/tb_btn_ctrl.sv
module tb_btn_ctrl;

    localparam int NB  = 2;
    localparam int DEB = 4;
    localparam int AW  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] btn;
    logic          irq;

    btn_ctrl_if #(.ADDR_WIDTH(AW)) bus_if ();

    btn_ctrl #(
        .ADDR_WIDTH      (AW),
        .NUM_BTNS        (NB),
        .DEBOUNCE_CYCLES (DEB),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .bus   (bus_if),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: synchroniser as a 2-deep delay line, debouncer as a
    // sliding window over the last DEB synchronised samples.
    logic [NB-1:0]  m_sync1;
    logic [NB-1:0]  m_sync2;
    logic [NB-1:0]  m_stable;
    logic [NB-1:0]  m_pend;
    logic [NB-1:0]  m_en;
    logic [DEB-1:0] m_hist [NB];
    logic [31:0]    last_rd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_sync1  = '0;
        m_sync2  = '0;
        m_stable = '0;
        m_pend   = '0;
        m_en     = '0;
        for (int c = 0; c < NB; c++) m_hist[c] = '0;
    endfunction

    function automatic logic [31:0] model_rdata(input logic re, input logic [AW-1:0] addr);
        logic [31:0] v;
        v = 32'h0;
        if (re) begin
            case (addr)
                8'd0:       v = 32'(m_stable);
                8'd1, 8'd3: v = 32'(m_pend);
                8'd2:       v = 32'(m_en);
                default:    v = 32'h0;
            endcase
        end
        return v;
    endfunction

    // Advance the model across one rising edge using the pre-edge inputs.
    function automatic void model_edge(input logic re, input logic we,
                                       input logic [AW-1:0] addr, input logic [31:0] wd);
        logic [NB-1:0] rise;
        rise = '0;
        for (int c = 0; c < NB; c++) begin
            m_hist[c] = {m_hist[c][DEB-2:0], m_sync2[c]};
            // Accept once the last DEB samples all disagree with stable.
            if (m_hist[c] == {DEB{~m_stable[c]}}) begin
                rise[c]     = ~m_stable[c];
                m_stable[c] = ~m_stable[c];
            end
        end
        if (re && addr == 8'd1) m_pend = rise;   // everything returned is cleared
        else                    m_pend = m_pend | rise;
        if (we && addr == 8'd2) m_en = wd[NB-1:0];
        m_sync2 = m_sync1;
        m_sync1 = ~btn;
    endfunction

    // One bus cycle, entered and left at posedge+1.
    task automatic cycle(input logic re, input logic we, input logic [AW-1:0] addr, input logic [31:0] wd);
        bus_if.read_enable  = re;
        bus_if.write_enable = we;
        bus_if.address      = addr;
        bus_if.data_in      = wd;
        #3;
        last_rd = bus_if.data_out;
        check_eq("data_out", bus_if.data_out, model_rdata(re, addr));
        check_eq("irq", 32'(irq), 32'(|(m_pend & m_en)));
        @(posedge clk);
        model_edge(re, we, addr, wd);
        #1;
        bus_if.read_enable  = 1'b0;
        bus_if.write_enable = 1'b0;
        bus_if.address      = '0;
        bus_if.data_in      = 32'h0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'd0, 32'h0);
    endtask

    task automatic rd(input logic [AW-1:0] addr);
        cycle(1'b1, 1'b0, addr, 32'h0);
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [31:0] wd);
        cycle(1'b0, 1'b1, addr, wd);
    endtask

    int hold [NB];
    int r;

    initial begin
        rst_n               = 1'b0;
        btn                 = 2'b11;
        bus_if.read_enable  = 1'b0;
        bus_if.write_enable = 1'b0;
        bus_if.address      = '0;
        bus_if.data_in      = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state of every register and of irq.
        for (int a = 0; a < 4; a++) begin
            rd(AW'(a));
            check_eq("reset_reg", last_rd, 32'h0);
        end
        check_eq("reset_irq", 32'(irq), 32'h0);

        // Clean press of btn[0]: accepted exactly DEB+2 edges later.
        btn = 2'b10;
        for (int i = 0; i < DEB + 2; i++) begin
            rd(8'd0);
            check_eq("status_before_accept", last_rd, 32'h0);
        end
        rd(8'd0);
        check_eq("status_after_accept", last_rd, 32'h1);
        rd(8'd3);
        check_eq("peek_press0", last_rd, 32'h1);
        rd(8'd1);
        check_eq("pend_read1", last_rd, 32'h1);
        rd(8'd1);
        check_eq("pend_read2", last_rd, 32'h0);

        // Glitch on btn[1] shorter than the debounce window is ignored.
        btn = 2'b00;
        idle(3);
        btn = 2'b10;
        idle(10);
        rd(8'd0);
        check_eq("glitch_status", last_rd, 32'h1);
        rd(8'd3);
        check_eq("glitch_peek", last_rd, 32'h0);
        check_eq("glitch_irq", 32'(irq), 32'h0);
        btn = 2'b00;
        idle(8);
        btn = 2'b10;
        idle(10);
        rd(8'd3);
        check_eq("long_pulse_peek", last_rd, 32'h2);
        rd(8'd1);

        // Interrupt masking.
        wr(8'd2, 32'hFFFF_FFFD);
        rd(8'd2);
        check_eq("irq_en_read", last_rd, 32'h1);
        btn = 2'b00;
        idle(10);
        check_eq("masked_irq", 32'(irq), 32'h0);
        btn = 2'b01;
        idle(10);
        btn = 2'b00;
        idle(10);
        check_eq("enabled_irq", 32'(irq), 32'h1);
        rd(8'd1);
        check_eq("irq_clear_read", last_rd, 32'h3);
        check_eq("irq_after_clear", 32'(irq), 32'h0);

        // Press edge of btn[1] lands on the edge that ends a PENDING read.
        btn = 2'b10;
        idle(10);
        btn = 2'b11;
        idle(10);
        btn = 2'b10;
        idle(10);
        btn = 2'b00;
        idle(DEB + 1);
        rd(8'd1);
        check_eq("aligned_read", last_rd, 32'h1);
        rd(8'd3);
        check_eq("aligned_peek", last_rd, 32'h2);

        // Sticky pending; releases set nothing.
        btn = 2'b11;
        idle(10);
        rd(8'd1);
        for (int k = 0; k < 2; k++) begin
            btn = 2'b10;
            idle(8);
            btn = 2'b11;
            idle(8);
        end
        rd(8'd3);
        check_eq("sticky_peek", last_rd, 32'h1);
        rd(8'd1);
        btn = 2'b10;
        idle(10);
        rd(8'd1);
        btn = 2'b11;
        idle(10);
        rd(8'd3);
        check_eq("release_peek", last_rd, 32'h0);

        // Asynchronous reset in the middle of a count, button held through it.
        wr(8'd2, 32'h3);
        btn = 2'b01;
        idle(10);
        btn = 2'b00;
        idle(2);
        bus_if.read_enable = 1'b1;
        bus_if.address     = 8'd0;
        #1;
        check_eq("pre_reset_status", bus_if.data_out, 32'h2);
        check_eq("pre_reset_irq", 32'(irq), 32'h1);
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_status", bus_if.data_out, 32'h0);
        check_eq("async_reset_irq", 32'(irq), 32'h0);
        bus_if.address = 8'd3;
        #1;
        check_eq("async_reset_peek", bus_if.data_out, 32'h0);
        bus_if.read_enable = 1'b0;
        bus_if.address     = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < DEB + 2; i++) begin
            rd(8'd3);
            check_eq("post_reset_peek_early", last_rd, 32'h0);
        end
        rd(8'd3);
        check_eq("post_reset_peek", last_rd, 32'h3);

        // Randomised traffic against the model.
        for (int c = 0; c < NB; c++) hold[c] = 0;
        for (int n = 0; n < 2000; n++) begin
            for (int c = 0; c < NB; c++) begin
                if (hold[c] == 0) begin
                    btn[c]  = 1'($urandom_range(0, 1));
                    hold[c] = $urandom_range(1, 10);
                end else begin
                    hold[c]--;
                end
            end
            r = $urandom_range(0, 99);
            cycle((r < 30), (r >= 20 && r < 35), AW'($urandom_range(0, 5)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
